aes_round_key_seq: RTL and testbench

//  Sequential AES key schedule: generates the FIPS-197 expanded key one 32-bit word per clock.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_subword.sv | 19 +
 rtl/aes_round_key_seq.sv | 207 ++++++++++++++++++++
 tb/tb_aes_round_key_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions for the key schedule and the round datapath:
//   the column count NB, the key-schedule FSM state type, the S-box table and
//   the small word/byte helpers (sbox, sub_word, rot_word, xtime).
//   Words are held as logic [31:0] with byte 0 in bits [31:24], so the
//   MSB-first byte order of the FIPS-197 notation maps directly onto them.
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte 0 moves to the last position: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// ----------------------------------------------------------------------------
// aes_subword
//   Combinational SubWord: four parallel S-box lookups on one 32-bit word.
//   Ports:
//     word_i  in  [31:0]  input word, byte 0 in [31:24]
//     word_o  out [31:0]  S-box substituted word, same byte order
// ----------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
    end

endmodule

// File: rtl/aes_round_key_seq.sv
// ----------------------------------------------------------------------------
// aes_round_key_seq
//   Sequential AES key expansion. Produces one expanded-key word per clock and
//   presents one 128-bit round key per valid/ready handshake, rounds 0..NR.
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     start     in   begin a new schedule (only looked at while idle)
//     key_in    in   cipher key, bit 0 = MSB of byte 0, captured on start
//     busy      out  schedule in progress
//     rk_valid  out  rk_data/rk_index hold a complete round key
//     rk_ready  in   consumer accepts the round key
//     rk_data   out  round key w[4r..4r+3], w[4r] in bits [0:31]
//     rk_index  out  round number of rk_data
//     done      out  one-cycle pulse after the round-NR handshake
// ----------------------------------------------------------------------------
module aes_round_key_seq
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:32*NK-1] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [0:127]     rk_data,
    output logic [3:0]       rk_index,
    output logic             done
);

    localparam int KIDX_W = $clog2(NK);
    localparam int WCNT_W = 6;
    localparam int KMOD_W = 3;
    localparam logic [WCNT_W-1:0] NK_WORDS   = WCNT_W'(NK);
    localparam logic [KMOD_W-1:0] KMOD_LAST  = KMOD_W'(NK - 1);
    localparam logic [KMOD_W-1:0] KMOD_SUB   = KMOD_W'(4);
    localparam logic [3:0]        LAST_ROUND = 4'(NR);

    ks_state_e          state_q, state_d;
    logic [31:0]        key_q [NK];
    logic [31:0]        win_q [NK];     // w[i-NK] .. w[i-1]
    logic [31:0]        acc_q [NB-1];   // first three words of the round in progress
    logic [WCNT_W-1:0]  wcnt_q;
    logic [KMOD_W-1:0]  kmod_q;
    logic [7:0]         rcon_q;
    logic [0:127]       rk_data_q;
    logic [3:0]         rk_index_q;
    logic               done_q;

    logic               load;
    logic               gen_en;
    logic               hs;
    logic               last_rk;
    logic               word_last;
    logic               in_key;
    logic [31:0]        sub_in;
    logic [31:0]        sub_out;
    logic [31:0]        t_word;
    logic [31:0]        word_d;

    assign last_rk   = (rk_index_q == LAST_ROUND);
    assign word_last = (wcnt_q[1:0] == 2'd3);
    assign in_key    = (wcnt_q < NK_WORDS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_GEN;
            ST_GEN:  if (word_last) state_d = ST_HOLD;
            ST_HOLD: if (rk_ready)  state_d = last_rk ? ST_IDLE : ST_GEN;
            default:                state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and internal strobes
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        rk_valid = 1'b0;
        load     = 1'b0;
        gen_en   = 1'b0;
        hs       = 1'b0;
        case (state_q)
            ST_IDLE: load = start;
            ST_GEN: begin
                busy   = 1'b1;
                gen_en = 1'b1;
            end
            ST_HOLD: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                hs       = rk_ready;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next expanded-key word. The S-box input is rotated only on the
    // first word of each NK-word group; the extra AES-256 SubWord step
    // shares the same S-box instance.
    // ------------------------------------------------------------------
    always_comb begin
        sub_in = (kmod_q == '0) ? rot_word(win_q[NK-1]) : win_q[NK-1];
    end

    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        t_word = win_q[NK-1];
        if (kmod_q == '0) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && kmod_q == KMOD_SUB) begin
            t_word = sub_out;
        end
        // Key-word indices >= NK are unreachable here: in_key gates them off.
        word_d = in_key ? key_q[wcnt_q[KIDX_W-1:0]] : (win_q[0] ^ t_word);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) begin
                key_q[i] <= '0;
                win_q[i] <= '0;
            end
            for (int i = 0; i < NB - 1; i++) begin
                acc_q[i] <= '0;
            end
            wcnt_q     <= '0;
            kmod_q     <= '0;
            rcon_q     <= 8'h01;
            rk_data_q  <= '0;
            rk_index_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= hs && last_rk;

            if (load) begin
                for (int i = 0; i < NK; i++) begin
                    key_q[i] <= key_in[32*i +: 32];
                    win_q[i] <= key_in[32*i +: 32];
                end
                wcnt_q     <= '0;
                kmod_q     <= '0;
                rcon_q     <= 8'h01;
                rk_index_q <= '0;
            end

            if (gen_en) begin
                // The fourth word bypasses acc so the key is ready on the
                // same edge that stores it.
                if (word_last) begin
                    rk_data_q <= {acc_q[0], acc_q[1], acc_q[2], word_d};
                end else begin
                    acc_q[wcnt_q[1:0]] <= word_d;
                end
                wcnt_q <= wcnt_q + 1'b1;

                if (!in_key) begin
                    for (int i = 0; i < NK - 1; i++) begin
                        win_q[i] <= win_q[i+1];
                    end
                    win_q[NK-1] <= word_d;
                    kmod_q      <= (kmod_q == KMOD_LAST) ? '0 : kmod_q + 1'b1;
                    if (kmod_q == '0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                end
            end

            // rk_index parks at NR after the final handshake.
            if (hs && !last_rk) begin
                rk_index_q <= rk_index_q + 1'b1;
            end
        end
    end

    assign rk_data  = rk_data_q;
    assign rk_index = rk_index_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_round_key_seq.sv
// ----------------------------------------------------------------------------
// tb_aes_round_key_seq
//   Drives three key-schedule instances (AES-128/192/256) and compares every
//   handshaked round key with a FIPS-197 style expansion computed in the bench
//   from a GF(2^8)-derived S-box.
// ----------------------------------------------------------------------------
module tb_aes_round_key_seq;

    logic           clk;
    logic           rst_n;
    logic           start_a [3];
    logic           ready_a [3];
    logic           busy_a  [3];
    logic           valid_a [3];
    logic           done_a  [3];
    logic [0:127]   data_a  [3];
    logic [3:0]     idx_a   [3];
    logic [0:127]   key4;
    logic [0:191]   key6;
    logic [0:255]   key8;

    int             n_chk  = 0;
    int             n_pass = 0;
    logic [7:0]     sb [256];
    logic [0:127]   ref_rk [15];
    logic [0:127]   cap_rk [15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_round_key_seq #(.NK(4)) u_nk4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .key_in(key4), .busy(busy_a[0]),
        .rk_valid(valid_a[0]), .rk_ready(ready_a[0]), .rk_data(data_a[0]),
        .rk_index(idx_a[0]), .done(done_a[0]));
    aes_round_key_seq #(.NK(6)) u_nk6 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .key_in(key6), .busy(busy_a[1]),
        .rk_valid(valid_a[1]), .rk_ready(ready_a[1]), .rk_data(data_a[1]),
        .rk_index(idx_a[1]), .done(done_a[1]));
    aes_round_key_seq #(.NK(8)) u_nk8 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .key_in(key8), .busy(busy_a[2]),
        .rk_valid(valid_a[2]), .rk_ready(ready_a[2]), .rk_data(data_a[2]),
        .rk_index(idx_a[2]), .done(done_a[2]));

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input int nk, input logic [0:255] key);
        logic [7:0] w [60][4];
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[(32*i + 8*j) +: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % nk == 0) begin
                tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
                rc = 8'h01;
                for (int k = 1; k < i / nk; k++) rc = gmul(rc, 8'h02);
                t[0] = t[0] ^ rc;
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
        end
        for (int r = 0; r <= nr; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) ref_rk[r][(32*c + 8*j) +: 8] = w[4*r + c][j];
    endtask

    // ---------------- stimulus ----------------
    task automatic set_key(input int sel, input logic [0:255] k);
        case (sel)
            0: key4 = k[0:127];
            1: key6 = k[0:191];
            default: key8 = k;
        endcase
    endtask

    function automatic logic [0:255] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; starts a schedule and consumes all round keys.
    // hold_round: stall rk_ready for 7 cycles on that key. glitch: pulse start
    // while busy. rst_round: assert reset while that round is being generated.
    task automatic run_sched(input int sel, input logic [0:255] key, input bit rnd_ready,
                             input int hold_round, input bit glitch, input int rst_round);
        int nk, nr, got, cyc, first_lat, hold_cnt, busy_err, done_err;
        bit rdy, aborted;
        nk = 4 + 2*sel; nr = nk + 6;
        model_expand(nk, key);
        set_key(sel, key);
        start_a[sel] = 1'b1;
        got = 0; cyc = 0; first_lat = -1; hold_cnt = 0; busy_err = 0; done_err = 0; aborted = 0;
        while (got <= nr && cyc < 400 && !aborted) begin
            @(negedge clk);
            cyc++;
            start_a[sel] = (glitch && cyc == 7);
            set_key(sel, rand_key());
            if (rst_round >= 0 && got == rst_round && !valid_a[sel]) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy_a[sel], 0);
                chk("rst_valid", valid_a[sel], 0);
                chk("rst_done", done_a[sel], 0);
                chk("rst_data", data_a[sel], 0);
                chk("rst_index", idx_a[sel], 0);
                aborted = 1;
            end else begin
                if (valid_a[sel] && first_lat < 0) first_lat = cyc;
                if (!busy_a[sel]) busy_err++;
                if (done_a[sel]) done_err++;
                if (valid_a[sel] && got == hold_round && hold_cnt < 7) begin
                    rdy = 1'b0;
                    hold_cnt++;
                    chk("hold_data", data_a[sel], ref_rk[got]);
                    chk("hold_index", idx_a[sel], got);
                end else begin
                    rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                ready_a[sel] = rdy;
                if (valid_a[sel] && rdy) begin
                    chk("rk_data", data_a[sel], ref_rk[got]);
                    chk("rk_index", idx_a[sel], got);
                    cap_rk[got] = data_a[sel];
                    got++;
                end
            end
        end
        start_a[sel] = 1'b0;
        if (!aborted) begin
            chk("handshakes", got, nr + 1);
            chk("first_latency", first_lat, 5);
            chk("busy_during_run", busy_err, 0);
            chk("done_early", done_err, 0);
            @(negedge clk);
            ready_a[sel] = 1'b0;
            chk("done_pulse", done_a[sel], 1);
            chk("busy_at_done", busy_a[sel], 0);
            chk("valid_at_done", valid_a[sel], 0);
            chk("index_parked", idx_a[sel], nr);
        end else begin
            ready_a[sel] = 1'b0;
        end
    endtask

    localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [0:255] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        logic [0:255] nk_key;
        build_sbox();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_a[s] = 1'b0;
            ready_a[s] = 1'b0;
        end
        key4 = '0; key6 = '0; key8 = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset_busy", busy_a[s], 0);
            chk("reset_valid", valid_a[s], 0);
            chk("reset_done", done_a[s], 0);
            chk("reset_data", data_a[s], 0);
            chk("reset_index", idx_a[s], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128 known answer, always ready
        run_sched(0, K128, 0, -1, 0, -1);
        chk("t1_rk0", cap_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("t1_rk1", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("t1_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        chk("done_one_cycle", done_a[0], 0);

        // backpressure at rk3, then random ready
        run_sched(0, K128, 0, 3, 0, -1);
        chk("t4_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        run_sched(0, K128, 1, -1, 0, -1);
        chk("t4r_rk1", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        @(negedge clk);

        // AES-192 / AES-256 known answers
        run_sched(1, K192, 0, -1, 0, -1);
        chk("t2_rk12", cap_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
        run_sched(2, K256, 0, -1, 0, -1);
        chk("t3_rk14", cap_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // start while busy is ignored; start in the done cycle is accepted
        run_sched(0, K128, 0, -1, 1, -1);
        chk("t5_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        nk_key = rand_key();
        run_sched(0, nk_key, 0, -1, 0, -1);
        chk("t5_b2b_rk0", cap_rk[0], nk_key[0:127]);
        @(negedge clk);

        // random keys, random ready, all key sizes
        for (int n = 0; n < 6; n++) begin
            run_sched(n % 3, rand_key(), 1, (n == 4) ? 7 : -1, 0, -1);
            @(negedge clk);
        end

        // reset while generating rk5, then a full clean restart
        run_sched(0, K128, 0, -1, 0, 5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sched(0, K128, 0, -1, 0, -1);
        chk("t6_rk0", cap_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("t6_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
